multicycle_ctrl_fsm: RTL and testbench

//  Multicycle MIPS main control unit. Decodes the same opcode set as the single-cycle

---
 rtl/multicycle_ctrl_fsm.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Main control unit of a multicycle MIPS datapath. Sequences each
//   instruction through FETCH/DECODE/EXEC/MEM/WB states against a shared
//   memory that signals completion with mem_ready_i, and drives the datapath
//   mux selects and write enables.
//
//   Supported opcodes: R(0) BGEZ(1) J(2) BEQ(4) BNE(5) BLT(6) ADDI(8)
//   SLTI(10) ORI(13) LUI(15) LW(35) SW(43). Any other opcode pulses
//   illegal_o in DECODE and is retired as a NOP.
//
//   Optional feature macro: JUMP_LINK_EN
//     defined   : op 3 (JAL) jumps and writes PC to $31; R-type with
//                 funct 8 (JR) jumps to rs.
//     undefined : op 3 is illegal; JR executes as an ordinary R-type.
//
// Parameters
//   OP_W        opcode width
//   ALU_OP_W    ALU-control code width (R=0 ADD=1 SUB=2 SLT=3 LUI=4 OR=5 BGEZ=6)
//   MEM_TIMEOUT memory wait cycles before mem_timeout_o sets (1..255)
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   instr_op_i, funct_i   opcode / funct from the instruction register
//   mem_ready_i           memory access completes this cycle
//   pc_write_o, branch_o  unconditional / conditional PC load
//   branch_type_o         0 BEQ, 1 BGEZ, 2 BLT, 3 BNE
//   pc_src_o              0 ALU, 1 ALUOut, 2 jump addr, 3 rs
//   iord_o                memory address select: 0 PC, 1 ALUOut
//   mem_read_o/_write_o   memory requests
//   ir_write_o            instruction register load
//   reg_write_o           register file write
//   reg_dst_o             0 rt, 1 rd, 2 $31
//   mem_to_reg_o          0 ALUOut, 1 MDR, 2 PC
//   alu_src_a_o           0 PC, 1 rs
//   alu_src_b_o           0 rt, 1 const 4, 2 sign-ext imm, 3 imm<<2
//   alu_op_o              ALU-control code
//   illegal_o             1-cycle pulse on unsupported opcode in DECODE
//   mem_timeout_o         sticky flag: a memory wait reached MEM_TIMEOUT
//   state_o               current state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int OP_W        = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic [5:0]          funct_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                branch_o,
  output logic [1:0]          branch_type_o,
  output logic [1:0]          pc_src_o,
  output logic                iord_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                illegal_o,
  output logic                mem_timeout_o,
  output logic [3:0]          state_o
);

  // State encoding
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  // Opcodes
  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_BGEZ = OP_W'(1);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);

  localparam logic [5:0] FN_JR = 6'd8;

  // ALU-control codes
  localparam logic [ALU_OP_W-1:0] ALU_R    = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_BGEZ = ALU_OP_W'(6);

  localparam logic [7:0] WAIT_MAX  = 8'hFF;
  localparam logic [7:0] WAIT_TRIP = 8'(MEM_TIMEOUT);

  logic [3:0]      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;

  logic [3:0]      dec_next;
  logic            dec_illegal;

`ifdef JUMP_LINK_EN
  logic            jr_q, jr_d;
  logic            dec_jr;
`else
  logic            unused_funct;
  assign unused_funct = ^funct_i;
`endif

  // ALU code for the EXEC state of ALU-class instructions
  function automatic logic [ALU_OP_W-1:0] exec_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_R:    return ALU_R;
      OP_SLTI: return ALU_SLT;
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  // Opcode classification, evaluated on the live instruction register
  // while in DECODE (op_q only becomes valid one cycle later).
  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
`ifdef JUMP_LINK_EN
    dec_jr      = 1'b0;
`endif
    case (instr_op_i)
      OP_R: begin
        dec_next = S_EXEC;
`ifdef JUMP_LINK_EN
        if (funct_i == FN_JR) begin
          dec_next = S_JUMP;
          dec_jr   = 1'b1;
        end
`endif
      end
      OP_ADDI, OP_SLTI, OP_ORI, OP_LUI:  dec_next = S_EXEC;
      OP_LW, OP_SW:                      dec_next = S_MEMADR;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGEZ:   dec_next = S_BRANCH;
      OP_J:                              dec_next = S_JUMP;
`ifdef JUMP_LINK_EN
      OP_JAL:                            dec_next = S_JUMP;
`endif
      default:                           dec_illegal = 1'b1;
    endcase
  end

  // Next-state, opcode latch, memory wait counter
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
`ifdef JUMP_LINK_EN
    jr_d    = jr_q;
`endif
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = instr_op_i;
        state_d = dec_next;
`ifdef JUMP_LINK_EN
        jr_d    = dec_jr;
`endif
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase

    // Only the three memory-wait states can stall; any state change
    // starts the count afresh for the next wait.
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)) &&
                 !mem_ready_i && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // Flag is raised by the edge on which the count reaches the limit;
    // the FSM itself keeps waiting.
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_TRIP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_FETCH;
      op_q          <= '0;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
`ifdef JUMP_LINK_EN
      jr_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
`ifdef JUMP_LINK_EN
      jr_q          <= jr_d;
`endif
    end
  end

  // Moore output decode of {state, op_q}; FETCH completion strobes follow
  // mem_ready_i so PC and IR load in the cycle the fetch actually lands.
  always_comb begin
    pc_write_o    = 1'b0;
    branch_o      = 1'b0;
    branch_type_o = 2'd0;
    pc_src_o      = 2'd0;
    iord_o        = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    reg_dst_o     = 2'd0;
    mem_to_reg_o  = 2'd0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'd0;
    alu_op_o      = ALU_R;
    illegal_o     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        alu_op_o    = ALU_ADD;
        pc_write_o  = mem_ready_i;
        ir_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm<<2) into ALUOut
        alu_src_b_o = 2'd3;
        alu_op_o    = ALU_ADD;
        illegal_o   = dec_illegal;
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'd1;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = (op_q == OP_R) ? 2'd0 : 2'd2;
        alu_op_o    = exec_alu_op(op_q);
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = (op_q == OP_R) ? 2'd1 : 2'd0;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        branch_o    = 1'b1;
        pc_src_o    = 2'd1;
        case (op_q)
          OP_BGEZ: begin branch_type_o = 2'd1; alu_op_o = ALU_BGEZ; end
          OP_BLT:  begin branch_type_o = 2'd2; alu_op_o = ALU_SLT;  end
          OP_BNE:  begin branch_type_o = 2'd3; alu_op_o = ALU_SUB;  end
          default: begin branch_type_o = 2'd0; alu_op_o = ALU_SUB;  end
        endcase
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'd2;
`ifdef JUMP_LINK_EN
        if (op_q == OP_JAL) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'd2;
          mem_to_reg_o = 2'd2;
        end
        if (jr_q) pc_src_o = 2'd3;
`endif
      end
      default: ;
    endcase

    // A reset cycle abandons the instruction without side effects
    if (rst_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      mem_write_o = 1'b0;
      branch_o    = 1'b0;
      illegal_o   = 1'b0;
    end
  end

  assign mem_timeout_o = mem_timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: a latency/state table per
// opcode, hand-built corner sequences, and randomized instruction streams
// checked cycle by cycle against an instruction-level expectation queue.
module tb_multicycle_ctrl_fsm;
  localparam int MEM_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic [5:0] funct_i;
  logic       mem_ready_i;
  logic       pc_write_o, branch_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_write_o, alu_src_a_o, illegal_o, mem_timeout_o;
  logic [1:0] branch_type_o, pc_src_o, reg_dst_o, mem_to_reg_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  multicycle_ctrl_fsm #(.OP_W(6), .ALU_OP_W(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .funct_i(funct_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .branch_o(branch_o),
    .branch_type_o(branch_type_o), .pc_src_o(pc_src_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .illegal_o(illegal_o), .mem_timeout_o(mem_timeout_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, br;
    logic [1:0] bt, pcs;
    logic       iord, mr, mw, irw, rw;
    logic [1:0] rd, m2r;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       ill;
  } outs_t;

  typedef struct {
    logic       ready;
    logic [5:0] op;
    logic [5:0] funct;
    outs_t      exp;
  } step_t;

  typedef struct {
    logic [5:0]       op;
    int               lat;
    logic [5:0][3:0]  st;    // st[5] is cycle 0
    logic [2:0]       aop2;  // alu_op expected in cycle 2
  } vec_t;

  typedef enum int {K_ALU, K_LW, K_SW, K_BR, K_JMP, K_ILL} kind_e;

  int    checks = 0;
  int    errors = 0;
  step_t sq[$];
  vec_t  vt[$];
  bit    to_sticky;
  int    stall_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t o;
    o.st = state_o; o.pcw = pc_write_o; o.br = branch_o; o.bt = branch_type_o;
    o.pcs = pc_src_o; o.iord = iord_o; o.mr = mem_read_o; o.mw = mem_write_o;
    o.irw = ir_write_o; o.rw = reg_write_o; o.rd = reg_dst_o; o.m2r = mem_to_reg_o;
    o.asa = alu_src_a_o; o.asb = alu_src_b_o; o.aop = alu_op_o; o.ill = illegal_o;
    return o;
  endfunction

  // Instruction class from the opcode list
  function automatic kind_e kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd0:                    begin
`ifdef JUMP_LINK_EN
        if (fn == 6'd8) return K_JMP;
`endif
        return (fn == fn) ? K_ALU : K_ALU;
      end
      6'd8, 6'd10, 6'd13, 6'd15: return K_ALU;
      6'd35:                   return K_LW;
      6'd43:                   return K_SW;
      6'd1, 6'd4, 6'd5, 6'd6:  return K_BR;
      6'd2:                    return K_JMP;
`ifdef JUMP_LINK_EN
      6'd3:                    return K_JMP;
`endif
      default:                 return K_ILL;
    endcase
  endfunction

  function automatic void push(input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                               input outs_t e);
    step_t s;
    s.ready = rdy; s.op = op; s.funct = fn; s.exp = e;
    sq.push_back(s);
  endfunction

  // Queue the expected per-cycle behaviour of one instruction; nf / nm are
  // the numbers of not-ready cycles in the fetch and data-memory waits.
  function automatic void push_instr(input logic [5:0] op, input logic [5:0] fn,
                                     input int nf, input int nm);
    outs_t o;
    kind_e k = kind_of(op, fn);
    for (int i = 0; i <= nf; i++) begin
      o = '0; o.st = 4'd0; o.mr = 1; o.asb = 2'd1; o.aop = 3'd1;
      o.pcw = (i == nf); o.irw = (i == nf);
      push(i == nf, 6'($urandom), 6'($urandom), o);
    end
    o = '0; o.st = 4'd1; o.asb = 2'd3; o.aop = 3'd1; o.ill = (k == K_ILL);
    push(1'($urandom), op, fn, o);
    case (k)
      K_LW, K_SW: begin
        o = '0; o.st = 4'd2; o.asa = 1; o.asb = 2'd2; o.aop = 3'd1;
        push(1'($urandom), 6'($urandom), 6'($urandom), o);
        for (int i = 0; i <= nm; i++) begin
          o = '0; o.iord = 1;
          if (k == K_LW) begin o.st = 4'd3; o.mr = 1; end
          else begin o.st = 4'd5; o.mw = 1; end
          push(i == nm, 6'($urandom), 6'($urandom), o);
        end
        if (k == K_LW) begin
          o = '0; o.st = 4'd4; o.rw = 1; o.m2r = 2'd1;
          push(1'($urandom), 6'($urandom), 6'($urandom), o);
        end
      end
      K_ALU: begin
        o = '0; o.st = 4'd6; o.asa = 1; o.asb = (op == 0) ? 2'd0 : 2'd2;
        case (op)
          6'd0: o.aop = 3'd0;  6'd8: o.aop = 3'd1;  6'd10: o.aop = 3'd3;
          6'd13: o.aop = 3'd5; default: o.aop = 3'd4;
        endcase
        push(1'($urandom), 6'($urandom), 6'($urandom), o);
        o = '0; o.st = 4'd7; o.rw = 1; o.rd = (op == 0) ? 2'd1 : 2'd0;
        push(1'($urandom), 6'($urandom), 6'($urandom), o);
      end
      K_BR: begin
        o = '0; o.st = 4'd8; o.asa = 1; o.br = 1; o.pcs = 2'd1;
        case (op)
          6'd4: begin o.bt = 2'd0; o.aop = 3'd2; end
          6'd1: begin o.bt = 2'd1; o.aop = 3'd6; end
          6'd6: begin o.bt = 2'd2; o.aop = 3'd3; end
          default: begin o.bt = 2'd3; o.aop = 3'd2; end
        endcase
        push(1'($urandom), 6'($urandom), 6'($urandom), o);
      end
      K_JMP: begin
        o = '0; o.st = 4'd9; o.pcw = 1; o.pcs = 2'd2;
        if (op == 6'd3) begin o.rw = 1; o.rd = 2'd2; o.m2r = 2'd2; end
        if (op == 6'd0) o.pcs = 2'd3;
        push(1'($urandom), 6'($urandom), 6'($urandom), o);
      end
      default: ;
    endcase
  endfunction

  // Must be entered at a falling edge; leaves at a falling edge.
  task automatic run_steps();
    step_t s;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      mem_ready_i = s.ready; instr_op_i = s.op; funct_i = s.funct;
      #1;
      chk("outs", 32'(dut_outs()), 32'(s.exp));
      chk("mem_timeout", 32'(mem_timeout_o), 32'(to_sticky));
      if ((s.exp.st == 4'd0 || s.exp.st == 4'd3 || s.exp.st == 4'd5) && !s.ready) begin
        stall_run++;
        if (stall_run >= MEM_TIMEOUT) to_sticky = 1'b1;
      end else begin
        stall_run = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; mem_ready_i = 1'b1; instr_op_i = 6'd35; funct_i = 6'd0;
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pc_write", 32'(pc_write_o), 32'd0);
    chk("rst_ir_write", 32'(ir_write_o), 32'd0);
    chk("rst_timeout", 32'(mem_timeout_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    to_sticky = 1'b0; stall_run = 0;
  endtask

  function automatic void add_vec(input logic [5:0] op, input int lat,
                                  input logic [23:0] st, input logic [2:0] aop2);
    vec_t v;
    v.op = op; v.lat = lat; v.st = st; v.aop2 = aop2;
    vt.push_back(v);
  endfunction

  logic [5:0] rand_ops[15] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd8, 6'd10,
                               6'd13, 6'd15, 6'd35, 6'd43, 6'd3, 6'd63, 6'd20};

  initial begin
    // Zero-wait state sequence and latency per opcode
    add_vec(6'd0,  4, 24'h016700, 3'd0);
    add_vec(6'd8,  4, 24'h016700, 3'd1);
    add_vec(6'd10, 4, 24'h016700, 3'd3);
    add_vec(6'd13, 4, 24'h016700, 3'd5);
    add_vec(6'd15, 4, 24'h016700, 3'd4);
    add_vec(6'd35, 5, 24'h012340, 3'd1);
    add_vec(6'd43, 4, 24'h012500, 3'd1);
    add_vec(6'd4,  3, 24'h018000, 3'd2);
    add_vec(6'd5,  3, 24'h018000, 3'd2);
    add_vec(6'd6,  3, 24'h018000, 3'd3);
    add_vec(6'd1,  3, 24'h018000, 3'd6);
    add_vec(6'd2,  3, 24'h019000, 3'd0);
    add_vec(6'd63, 2, 24'h010000, 3'd1);
`ifndef JUMP_LINK_EN
    add_vec(6'd3,  2, 24'h010000, 3'd1);
`endif

    do_reset();

    foreach (vt[n]) begin
      for (int i = 0; i <= vt[n].lat; i++) begin
        mem_ready_i = 1'b1; funct_i = 6'd0;
        instr_op_i = (i == 1) ? vt[n].op : 6'($urandom);
        #1;
        chk($sformatf("tbl_op%0d_c%0d_state", vt[n].op, i), 32'(state_o), 32'(vt[n].st[5-i]));
        if (i == 2) chk($sformatf("tbl_op%0d_aluop", vt[n].op), 32'(alu_op_o), 32'(vt[n].aop2));
        if (i < vt[n].lat) @(negedge clk);
      end
    end
    @(negedge clk);

    // LW with a 3-cycle stall in MEMRD, then BNE, then illegal 63, then op 3
    do_reset();
    push_instr(6'd35, 6'd0, 0, 3);
    push_instr(6'd5, 6'd0, 0, 0);
    push_instr(6'd63, 6'd0, 0, 0);
    push_instr(6'd3, 6'd0, 0, 0);
    run_steps();

    // Fetch stalled 20 cycles: timeout on cycle 16, sticky afterwards
    do_reset();
    push_instr(6'd0, 6'd0, 20, 0);
    push_instr(6'd8, 6'd0, 0, 0);
    run_steps();
    #1;
    chk("timeout_sticky", 32'(mem_timeout_o), 32'd1);
    @(negedge clk);

    // Reset while in MEMWB: write strobe suppressed, back to FETCH
    do_reset();
    push_instr(6'd35, 6'd0, 0, 0);
    void'(sq.pop_back());
    run_steps();
    rst_i = 1'b1; mem_ready_i = 1'b1;
    #1;
    chk("midrst_state", 32'(state_o), 32'd4);
    chk("midrst_reg_write", 32'(reg_write_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("midrst_after_state", 32'(state_o), 32'd0);
    @(negedge clk);

    // Randomized instruction stream with random memory stalls
    do_reset();
    for (int n = 0; n < 80; n++) begin
      int nf, nm;
      nf = ($urandom_range(0, 15) == 0) ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 2));
      nm = ($urandom_range(0, 15) == 0) ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 2));
      push_instr(rand_ops[$urandom_range(0, 14)], 6'($urandom), nf, nm);
      run_steps();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
